// File: rtl/aux_reply_decoder_if.sv
// rtl/aux_reply_decoder_if.sv - PHY receive, ctrl request context and decoded reply signals
interface aux_reply_decoder_if;
    logic       phy_rx_vld;
    logic [7:0] phy_rx_data;
    logic       phy_rx_done;
    logic       phy_rx_err;
    logic       ctrl_tr_vld;
    logic [1:0] ctrl_msg_cmd;
    logic [7:0] ctrl_msg_len;
    logic       ctrl_i2c_native;
    logic [1:0] reply_ack;
    logic       reply_ack_vld;
    logic [7:0] reply_data;
    logic       reply_data_vld;
    logic       reply_err;
    logic [7:0] stat_err_cnt;
    logic [7:0] stat_defer_cnt;

    modport master (
        output phy_rx_vld, phy_rx_data, phy_rx_done, phy_rx_err,
        output ctrl_tr_vld, ctrl_msg_cmd, ctrl_msg_len, ctrl_i2c_native,
        input  reply_ack, reply_ack_vld, reply_data, reply_data_vld, reply_err,
        input  stat_err_cnt, stat_defer_cnt
    );

    modport slave (
        input  phy_rx_vld, phy_rx_data, phy_rx_done, phy_rx_err,
        input  ctrl_tr_vld, ctrl_msg_cmd, ctrl_msg_len, ctrl_i2c_native,
        output reply_ack, reply_ack_vld, reply_data, reply_data_vld, reply_err,
        output stat_err_cnt, stat_defer_cnt
    );
endinterface

// File: rtl/aux_reply_decoder.sv
// rtl/aux_reply_decoder.sv - AUX reply decoder; AUX_RX_STATS_EN enables error/defer counters
module aux_reply_decoder #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    aux_reply_decoder_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_RX_BODY, S_CHECK, S_ACK_OUT, S_DATA_OUT
    } state_t;

    state_t          state, state_nxt;
    logic            tr_vld_q;
    logic            tr_rise;
    logic [1:0]      ctx_cmd;
    logic [7:0]      ctx_len;
    logic            ctx_i2c;
    logic [7:0]      hdr;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   rd_idx;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [1:0]      ack_q;
    logic            err_q;

    logic            push, hdr_load, flush, err_evt, ack_load, rd_clr, rd_inc;
    logic [1:0]      code;
    logic            hdr_ok, cnt_ok, reply_ok;
    logic [8:0]      cnt_ext, max_rd;

    assign tr_rise = bus.ctrl_tr_vld & ~tr_vld_q;

    // Code field position depends on native vs I2C-over-AUX; the other 2-bit field must be zero.
    always_comb begin
        code    = ctx_i2c ? hdr[7:6] : hdr[5:4];
        hdr_ok  = (hdr[3:0] == 4'b0000) && (code != 2'b11) &&
                  (ctx_i2c ? (hdr[5:4] == 2'b00) : (hdr[7:6] == 2'b00));
        cnt_ext = 9'(cnt);
        max_rd  = {1'b0, ctx_len} + 9'd1;
        cnt_ok  = 1'b0;
        case (code)
            2'b00: begin
                if (ctx_cmd == 2'b01)
                    cnt_ok = (cnt != '0) && (cnt_ext <= max_rd) && (cnt <= DEPTH_C);
                else if (ctx_cmd == 2'b00)
                    cnt_ok = (cnt == '0);
            end
            2'b01: begin
                if (ctx_cmd == 2'b00)
                    cnt_ok = (cnt == CW'(1));
                else if (ctx_cmd == 2'b01)
                    cnt_ok = (cnt == '0);
            end
            2'b10:   cnt_ok = (cnt == '0);
            default: cnt_ok = 1'b0;
        endcase
        reply_ok = hdr_ok && cnt_ok;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        hdr_load  = 1'b0;
        flush     = 1'b0;
        err_evt   = 1'b0;
        ack_load  = 1'b0;
        rd_clr    = 1'b0;
        rd_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                if (tr_rise)
                    state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (bus.phy_rx_err) begin
                    flush   = 1'b1;
                    err_evt = 1'b1;
                end else if (bus.phy_rx_vld) begin
                    hdr_load  = 1'b1;
                    flush     = 1'b1;
                    state_nxt = bus.phy_rx_done ? S_CHECK : S_RX_BODY;
                end else if (bus.phy_rx_done) begin
                    err_evt = 1'b1;
                end
            end
            S_RX_BODY: begin
                // A new request supersedes the reply in flight without flagging an error.
                if (tr_rise) begin
                    flush     = 1'b1;
                    state_nxt = S_ARMED;
                end else if (bus.phy_rx_err) begin
                    flush     = 1'b1;
                    err_evt   = 1'b1;
                    state_nxt = S_ARMED;
                end else begin
                    push = bus.phy_rx_vld;
                    if (bus.phy_rx_done)
                        state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (tr_rise) begin
                    flush     = 1'b1;
                    state_nxt = S_ARMED;
                end else if (reply_ok) begin
                    ack_load  = 1'b1;
                    state_nxt = S_ACK_OUT;
                end else begin
                    flush     = 1'b1;
                    err_evt   = 1'b1;
                    state_nxt = S_ARMED;
                end
            end
            S_ACK_OUT: begin
                rd_clr    = 1'b1;
                err_evt   = bus.phy_rx_vld;
                state_nxt = (cnt != '0) ? S_DATA_OUT : S_ARMED;
            end
            S_DATA_OUT: begin
                rd_inc  = 1'b1;
                err_evt = bus.phy_rx_vld;
                if (rd_idx + CW'(1) == cnt)
                    state_nxt = S_ARMED;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.reply_ack      = ack_q;
        bus.reply_err      = err_q;
        bus.reply_ack_vld  = (state == S_ACK_OUT);
        bus.reply_data_vld = (state == S_DATA_OUT);
        bus.reply_data     = 8'h00;
        if (state == S_DATA_OUT)
            bus.reply_data = mem[rd_idx[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tr_vld_q <= 1'b0;
            ctx_cmd  <= 2'b00;
            ctx_len  <= 8'h00;
            ctx_i2c  <= 1'b0;
            hdr      <= 8'h00;
            cnt      <= '0;
            rd_idx   <= '0;
            ack_q    <= 2'b00;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            tr_vld_q <= bus.ctrl_tr_vld;
            err_q    <= err_evt;
            if (tr_rise) begin
                ctx_cmd <= bus.ctrl_msg_cmd;
                ctx_len <= bus.ctrl_msg_len;
                ctx_i2c <= bus.ctrl_i2c_native;
            end
            if (hdr_load)
                hdr <= bus.phy_rx_data;
            // Saturating one past the buffer depth keeps an overlong reply detectably invalid.
            if (flush)
                cnt <= '0;
            else if (push && (cnt != CNT_MAX))
                cnt <= cnt + CW'(1);
            if (rd_clr)
                rd_idx <= '0;
            else if (rd_inc)
                rd_idx <= rd_idx + CW'(1);
            if (ack_load)
                ack_q <= code;
        end
    end

    always_ff @(posedge clk) begin
        if (push && (cnt < DEPTH_C))
            mem[cnt[AW-1:0]] <= bus.phy_rx_data;
    end

`ifdef AUX_RX_STATS_EN
    logic [7:0] err_cnt, defer_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt   <= 8'h00;
            defer_cnt <= 8'h00;
        end else begin
            if (err_q && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
            if ((state == S_ACK_OUT) && (ack_q == 2'b10) && (defer_cnt != 8'hFF))
                defer_cnt <= defer_cnt + 8'd1;
        end
    end

    assign bus.stat_err_cnt   = err_cnt;
    assign bus.stat_defer_cnt = defer_cnt;
`else
    assign bus.stat_err_cnt   = 8'h00;
    assign bus.stat_defer_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_aux_reply_decoder.sv
// tb/tb_aux_reply_decoder.sv - directed self-checking bench for aux_reply_decoder
module tb_aux_reply_decoder;
    logic clk;
    logic rst_n;
    aux_reply_decoder_if bus ();

    aux_reply_decoder #(.FIFO_DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_err_tot = 0;

    int         cyc = 0;
    int         done_cyc = 0;
    logic [1:0] ack_codes[$];
    int         ack_cycs[$];
    logic [7:0] data_q[$];
    int         data_cycs[$];
    int         err_n = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.phy_rx_done) done_cyc = cyc;
        if (bus.reply_ack_vld) begin
            ack_codes.push_back(bus.reply_ack);
            ack_cycs.push_back(cyc);
        end
        if (bus.reply_data_vld) begin
            data_q.push_back(bus.reply_data);
            data_cycs.push_back(cyc);
        end
        if (bus.reply_err) err_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ack_codes.delete();
        ack_cycs.delete();
        data_q.delete();
        data_cycs.delete();
        err_n = 0;
    endtask

    task automatic start_req(input logic [1:0] cmd, input logic [7:0] len, input logic i2c);
        bus.ctrl_tr_vld = 1'b0;
        tick();
        bus.ctrl_msg_cmd    = cmd;
        bus.ctrl_msg_len    = len;
        bus.ctrl_i2c_native = i2c;
        bus.ctrl_tr_vld     = 1'b1;
        tick();
        bus.ctrl_msg_cmd    = 2'b11;
        bus.ctrl_msg_len    = 8'hFF;
        bus.ctrl_i2c_native = ~i2c;
    endtask

    task automatic send_reply(input bit merge_done);
        for (int i = 0; i < rx_q.size(); i++) begin
            bus.phy_rx_vld  = 1'b1;
            bus.phy_rx_data = rx_q[i];
            if (merge_done && (i == rx_q.size() - 1)) bus.phy_rx_done = 1'b1;
            tick();
        end
        bus.phy_rx_vld = 1'b0;
        if (!merge_done) begin
            bus.phy_rx_done = 1'b1;
            tick();
        end
        bus.phy_rx_done = 1'b0;
    endtask

    task automatic check_reply(input string tag, input int n_ack, input logic [1:0] code, input int n_err);
        repeat (30) tick();
        check({tag, "/acks"}, ack_codes.size(), n_ack);
        for (int i = 0; i < ack_codes.size(); i++)
            check({tag, "/code"}, ack_codes[i], code);
        if (ack_cycs.size() > 0)
            check({tag, "/lat"}, ack_cycs[ack_cycs.size()-1] - done_cyc, 2);
        check({tag, "/ndata"}, data_q.size(), exp_q.size());
        for (int i = 0; i < data_q.size() && i < exp_q.size(); i++) begin
            check({tag, "/data"}, data_q[i], exp_q[i]);
            if (ack_cycs.size() > 0)
                check({tag, "/gap"}, data_cycs[i] - ack_cycs[ack_cycs.size()-1], i + 1);
        end
        check({tag, "/err"}, err_n, n_err);
        exp_err_tot += n_err;
        clr();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.phy_rx_vld = 1'b0;
        bus.phy_rx_data = 8'h00;
        bus.phy_rx_done = 1'b0;
        bus.phy_rx_err = 1'b0;
        bus.ctrl_tr_vld = 1'b0;
        bus.ctrl_msg_cmd = 2'b00;
        bus.ctrl_msg_len = 8'h00;
        bus.ctrl_i2c_native = 1'b0;
        repeat (3) tick();
        check("rst/ack", bus.reply_ack, 2'b00);
        check("rst/ack_vld", bus.reply_ack_vld, 1'b0);
        check("rst/data_vld", bus.reply_data_vld, 1'b0);
        check("rst/data", bus.reply_data, 8'h00);
        check("rst/err", bus.reply_err, 1'b0);
        check("rst/stat_err", bus.stat_err_cnt, 8'h00);
        rst_n = 1'b1;
        tick();
        clr();

        // Native read, len=3
        start_req(2'b01, 8'd3, 1'b0);
        rx_q = {8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        exp_q = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_reply(1'b0);
        check_reply("nat_rd", 1, 2'b00, 0);

        // Native write, NACK with M=2
        start_req(2'b00, 8'd5, 1'b0);
        rx_q = {8'h10, 8'h02};
        exp_q = {8'h02};
        send_reply(1'b0);
        check_reply("nat_wr_nack", 1, 2'b01, 0);

        // DEFER three times on a single request
        start_req(2'b00, 8'd0, 1'b0);
        rx_q = {8'h20};
        exp_q.delete();
        for (int r = 0; r < 3; r++) begin
            send_reply(1'b0);
            repeat (5) tick();
        end
        check_reply("defer3", 3, 2'b10, 0);
`ifdef AUX_RX_STATS_EN
        check("stat_defer", bus.stat_defer_cnt, 8'd3);
`else
        check("stat_defer", bus.stat_defer_cnt, 8'd0);
`endif

        // Too many bytes for len=1, then bad code
        start_req(2'b01, 8'd1, 1'b0);
        rx_q = {8'h00, 8'h11, 8'h22, 8'h33};
        send_reply(1'b0);
        check_reply("rd_overlen", 0, 2'b00, 1);
        check("held_ack", bus.reply_ack, 2'b10);
        rx_q = {8'h30};
        send_reply(1'b0);
        check_reply("bad_code", 0, 2'b00, 1);
        rx_q = {8'h00, 8'h77};
        exp_q = {8'h77};
        send_reply(1'b0);
        check_reply("after_flush", 1, 2'b00, 0);

        // I2C read, len=0
        start_req(2'b01, 8'd0, 1'b1);
        rx_q = {8'h00, 8'h5A};
        exp_q = {8'h5A};
        send_reply(1'b0);
        check_reply("i2c_rd", 1, 2'b00, 0);
        rx_q = {8'h40};
        exp_q.delete();
        send_reply(1'b0);
        check_reply("i2c_nack", 1, 2'b01, 0);
        rx_q = {8'h00, 8'hC7};
        exp_q = {8'hC7};
        send_reply(1'b1);
        check_reply("i2c_merged", 1, 2'b00, 0);

        // Full 16-byte payload, then 17 bytes
        start_req(2'b01, 8'd15, 1'b0);
        rx_q = {8'h00};
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            rx_q.push_back(8'(i * 13 + 5));
            exp_q.push_back(8'(i * 13 + 5));
        end
        send_reply(1'b0);
        check_reply("full16", 1, 2'b00, 0);
        start_req(2'b01, 8'd255, 1'b0);
        rx_q.push_back(8'hEE);
        exp_q.delete();
        send_reply(1'b0);
        check_reply("over17", 0, 2'b00, 1);

        // PHY error mid-body
        bus.phy_rx_vld = 1'b1; bus.phy_rx_data = 8'h00; tick();
        bus.phy_rx_data = 8'h11; tick();
        bus.phy_rx_vld = 1'b0; bus.phy_rx_err = 1'b1; tick();
        bus.phy_rx_err = 1'b0;
        check_reply("phy_err", 0, 2'b00, 1);

        // New request aborts reply in flight silently
        bus.phy_rx_vld = 1'b1; bus.phy_rx_data = 8'h00; tick();
        bus.phy_rx_data = 8'h11; tick();
        bus.phy_rx_vld = 1'b0;
        start_req(2'b00, 8'd0, 1'b0);
        check_reply("abort", 0, 2'b00, 0);
        rx_q = {8'h00};
        send_reply(1'b0);
        check_reply("relatched_wr", 1, 2'b00, 0);

        // STOP with no header
        bus.phy_rx_done = 1'b1; tick();
        bus.phy_rx_done = 1'b0;
        check_reply("no_hdr", 0, 2'b00, 1);

        // Stray byte during payload burst
        start_req(2'b01, 8'd3, 1'b0);
        rx_q = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        exp_q = {8'h01, 8'h02, 8'h03, 8'h04};
        send_reply(1'b0);
        tick();
        tick();
        bus.phy_rx_vld = 1'b1; bus.phy_rx_data = 8'hEE; tick();
        bus.phy_rx_vld = 1'b0;
        check_reply("stray", 1, 2'b00, 1);

`ifdef AUX_RX_STATS_EN
        check("stat_err", bus.stat_err_cnt, 8'(exp_err_tot));
`else
        check("stat_err", bus.stat_err_cnt, 8'd0);
`endif

        // Reset during DATA_OUT
        start_req(2'b00, 8'd0, 1'b0);
        rx_q = {8'h10, 8'h09};
        send_reply(1'b0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        bus.ctrl_tr_vld = 1'b0;
        #1;
        check("rstmid/data_vld", bus.reply_data_vld, 1'b0);
        check("rstmid/data", bus.reply_data, 8'h00);
        check("rstmid/ack", bus.reply_ack, 2'b00);
        check("rstmid/stat_err", bus.stat_err_cnt, 8'h00);
        check("rstmid/stat_defer", bus.stat_defer_cnt, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        clr();
        rx_q = {8'h00, 8'h11};
        exp_q.delete();
        send_reply(1'b0);
        check_reply("idle_ignore", 0, 2'b00, 0);
        start_req(2'b01, 8'd1, 1'b0);
        rx_q = {8'h00, 8'h11};
        exp_q = {8'h11};
        send_reply(1'b0);
        check_reply("post_rst_rd", 1, 2'b00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
